// File: rtl/dor_pkg.sv
// Shared definitions for the dor OR-gate input path: default debounce depth and the level type.
package dor_pkg;

  localparam int unsigned DOR_DEBOUNCE_DEFAULT = 4;

  typedef logic dor_level_t;

endpackage

// File: rtl/dor_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, registered clean level.
// Latency DEBOUNCE_CYCLES+2 edges from first sample; no backpressure. Edge pulses under DOR_DEBOUNCE_EDGE_EN.
module dor_debounce_ch
  import dor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DOR_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  output dor_level_t clean
`ifdef DOR_DEBOUNCE_EDGE_EN
  ,
  output logic       rise,
  output logic       fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  dor_level_t       s1;
  dor_level_t       s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
`ifdef DOR_DEBOUNCE_EDGE_EN
      rise  <= 1'b0;
      fall  <= 1'b0;
`endif
    end else begin
      s1 <= raw;
      s2 <= s1;
`ifdef DOR_DEBOUNCE_EDGE_EN
      rise <= 1'b0;
      fall <= 1'b0;
`endif
      // Always compare against the current clean level, so a bounce back clears the count.
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        clean <= s2;
        cnt   <= '0;
`ifdef DOR_DEBOUNCE_EDGE_EN
        rise  <= s2;
        fall  <= ~s2;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dor_debounce.sv
// Two independent debounced channels feeding dor.a / dor.b; optional edge pulses via DOR_DEBOUNCE_EDGE_EN.
// Latency DEBOUNCE_CYCLES+2 edges per channel; no backpressure (level inputs).
module dor_debounce
  import dor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DOR_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean
`ifdef DOR_DEBOUNCE_EDGE_EN
  ,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
`endif
);

  dor_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (a_raw),
    .clean (a_clean)
`ifdef DOR_DEBOUNCE_EDGE_EN
    ,
    .rise  (a_rise),
    .fall  (a_fall)
`endif
  );

  dor_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (b_raw),
    .clean (b_clean)
`ifdef DOR_DEBOUNCE_EDGE_EN
    ,
    .rise  (b_rise),
    .fall  (b_fall)
`endif
  );

endmodule

// File: doc/dor_debounce.md
# dor_debounce

Two-channel input conditioner directly upstream of the `dor` OR gate. It takes two raw, asynchronous switch/pin levels and synchronises them to `clk`. It debounces each one with a per-channel stability counter. The result is two clean, glitch-free levels that drive the `a` and `b` inputs of `dor`, so `y` never toggles on bounce or metastability.

## Interface
- `DEBOUNCE_CYCLES`, default 4, is the number of consecutive synchronised samples that must differ from the current output before that output changes. Legal range is 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`, is the width of the per-channel counter. It is derived and must not be overridden.
- `clk` input 1: single clock; all state is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `a_raw` input 1: raw level for channel A, asynchronous to `clk`.
- `b_raw` input 1: raw level for channel B, asynchronous to `clk`.
- `a_clean` output 1: debounced level for channel A; feeds `dor.a`.
- `b_clean` output 1: debounced level for channel B; feeds `dor.b`.
- `a_rise`, `a_fall`, `b_rise`, `b_fall` output 1 each: single-cycle edge pulses. These ports exist only with `DOR_DEBOUNCE_EDGE_EN`.

## Operation
- The two channels are identical and fully independent, with no shared state.
- Each channel has a 2-flop synchroniser, `s1` then `s2`, fed from the raw input.
- Each channel has one counter, `cnt`, of width `CNT_W`, and one output register, `clean`.
- Per channel, on each rising edge of `clk`:
  - `s1` is loaded from the raw input, and `s2` is loaded from `s1`.
  - If `s2 == clean`, then `cnt` is set to 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `clean` is set to `s2` and `cnt` is set to 0.
  - Else `cnt` is incremented by 1.
- Per-channel state is implicit in the counter:
  - STABLE: `cnt==0` and `s2==clean`.
  - PENDING: `s2!=clean`; the counter is running.
  - PENDING returns to STABLE when `s2` reverts before the count completes. This is a glitch: it is rejected, `cnt` clears, and `clean` is unchanged.
  - PENDING returns to STABLE with `clean` updated when the count completes.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- The comparison is always against the current `clean`. A bounce that settles back to the old level never produces an output change.
- Reset applies to all flops asynchronously on `rst_n` low:
  - `s1`, `s2`, `cnt` and `clean` all go to 0.
  - All edge pulses go to 0.
- Reset asserted mid-count discards the pending count.
- After `rst_n` deasserts, a raw input that is held high needs the full latency before its `clean` output rises.

## Timing
- Edge k is the first rising edge that samples a new, held raw level.
- `s2` holds the new level after edge k+1.
- The comparisons happen on edges k+2 through k+1+`DEBOUNCE_CYCLES`.
- `clean` changes on edge k+1+`DEBOUNCE_CYCLES`. With the default of 4, that is edge k+5, i.e. 6 edges after the first sample.
- A raw pulse shorter than `DEBOUNCE_CYCLES` synchronised samples produces no output change.
- A pulse exactly `DEBOUNCE_CYCLES` samples long does produce an output change.
- `clean` outputs come straight from flops, with no combinational path from input to output.
- When both channels change simultaneously, they update on the same edge and do not interact.

## Configuration
- The macro is `DOR_DEBOUNCE_EDGE_EN`.
- When defined, the four edge-pulse outputs exist and are registered.
- `x_rise` is high for exactly the one cycle that follows the edge on which `x_clean` goes 0 to 1.
- `x_fall` behaves the same way for `x_clean` going 1 to 0.
- The pulses are generated from the same update condition as `clean`; they are not a delayed compare. This puts them coincident with the new `clean` value.
- When not defined, the ports and their logic are absent, and the `clean` behaviour is identical in both builds.

## Structure
- Shared package `dor_pkg` contains:
  - `DOR_DEBOUNCE_DEFAULT = 4`.
  - A `dor_level_t` typedef for a 1-bit level.
- The natural sub-module is `dor_debounce_ch`, which holds one synchroniser, one counter and one output register, plus the optional edge pulses.
- The top level instantiates `dor_debounce_ch` twice. It contains no other logic.

## Test plan
- Reset and steady input:
  - Stimulus: `rst_n` low with both raw inputs at 1, then release and hold both at 1.
  - Required response: both `clean` outputs read 0 during reset, then rise together on the 6th edge after release.
- Glitch rejection:
  - Stimulus: `a_raw` pulsed high for 3 cycles with `DEBOUNCE_CYCLES=4`.
  - Required response: `a_clean` stays 0 and `cnt` returns to 0.
- Exact threshold:
  - Stimulus: `a_raw` pulsed high for exactly 4 cycles.
  - Required response: `a_clean` rises on edge k+5, then falls 4 samples after the raw level falls.
- Bounce train:
  - Stimulus: `b_raw` toggles 1,0,1,0,1 per cycle, then holds at 1.
  - Required response: `b_clean` rises exactly 5 edges after the final 0 to 1 transition is sampled, with no intermediate toggles.
- Reset mid-count:
  - Stimulus: `rst_n` asserted 2 cycles into a PENDING period.
  - Required response: outputs go to 0 immediately (asynchronously), and the count restarts from 0 after release.
- Edge pulses, with `DOR_DEBOUNCE_EDGE_EN` defined:
  - Stimulus: one clean rise on channel A, then one clean fall.
  - Required response: `a_rise` is high for exactly one cycle coincident with `a_clean` becoming 1, and `a_fall` is high for one cycle when it becomes 0. The B pulses stay 0 throughout.
